// File: rtl/clk_divider_multi_if.sv
// rtl/clk_divider_multi_if.sv - divisor write port and pending-status bundle
interface clk_divider_multi_if #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 24,
  parameter int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
);
  logic              wr_en;
  logic [CH_W-1:0]   wr_ch;
  logic [WIDTH-1:0]  wr_data;
  logic [N_CH-1:0]   pend;

  modport master (output wr_en, output wr_ch, output wr_data, input pend);
  modport slave  (input wr_en, input wr_ch, input wr_data, output pend);
endinterface

// File: rtl/clk_divider_multi.sv
// rtl/clk_divider_multi.sv - multi-channel programmable clock/tick divider
module clk_divider_multi #(
  parameter int N_CH        = 4,
  parameter int WIDTH       = 24,
  parameter int DEFAULT_DIV = 5999999
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       en,
  input  logic                  sync,
  clk_divider_multi_if.slave    wr,
  output logic [N_CH-1:0]       clk_out,
  output logic [N_CH-1:0]       tick
);

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);

  logic [N_CH-1:0] pend;
  assign wr.pend = pend;

  genvar i;
  generate
    for (i = 0; i < N_CH; i++) begin : g_ch
      logic [WIDTH-1:0] cnt;
      logic [WIDTH-1:0] act;
      logic [WIDTH-1:0] shd;
      logic             pend_r;
      logic             clk_r;
      logic             tick_r;
      logic             wr_hit;
      logic             tc;

      // Index compared at full width so out-of-range indices never alias a channel.
      assign wr_hit = wr.wr_en && (32'(wr.wr_ch) == i);
      assign tc     = (cnt == act);

      // Per-channel divider: disable beats sync beats terminal count; act only changes while cnt restarts at 0.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt    <= '0;
          act    <= DEF_DIV;
          shd    <= DEF_DIV;
          pend_r <= 1'b0;
          clk_r  <= 1'b0;
          tick_r <= 1'b0;
        end else if (!en[i]) begin
          cnt    <= '0;
          clk_r  <= 1'b0;
          tick_r <= 1'b0;
          pend_r <= 1'b0;
          if (wr_hit) begin
            act <= wr.wr_data;
            shd <= wr.wr_data;
          end else begin
            act <= shd;
          end
        end else if (sync) begin
          cnt    <= '0;
          clk_r  <= 1'b0;
          tick_r <= 1'b0;
          if (wr_hit) begin
            shd    <= wr.wr_data;
            pend_r <= 1'b1;
          end
        end else if (tc) begin
          cnt    <= '0;
          tick_r <= 1'b1;
          clk_r  <= ~clk_r;
          pend_r <= 1'b0;
          if (wr_hit) begin
            act <= wr.wr_data;
            shd <= wr.wr_data;
          end else if (pend_r) begin
            act <= shd;
          end
        end else begin
          cnt    <= cnt + 1'b1;
          tick_r <= 1'b0;
          if (wr_hit) begin
            shd    <= wr.wr_data;
            pend_r <= 1'b1;
          end
        end
      end

      assign clk_out[i] = clk_r;
      assign tick[i]    = tick_r;
      assign pend[i]    = pend_r;
    end
  endgenerate

endmodule

// File: tb/tb_clk_divider_multi.sv
// tb/tb_clk_divider_multi.sv - randomized bench against an event-time divider model
module tb_clk_divider_multi;
  localparam int N_CH  = 4;
  localparam int WIDTH = 8;
  localparam int DEF   = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N_CH-1:0] en = '0;
  logic            sync = 1'b0;
  logic [N_CH-1:0] clk_out;
  logic [N_CH-1:0] tick;

  clk_divider_multi_if #(.N_CH(N_CH), .WIDTH(WIDTH), .CH_W(3)) wr_if ();

  clk_divider_multi #(.N_CH(N_CH), .WIDTH(WIDTH), .DEFAULT_DIV(DEF)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .sync    (sync),
    .wr      (wr_if.slave),
    .clk_out (clk_out),
    .tick    (tick)
  );

  // 12 MHz stand-in clock
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int t     = 0;

  // Model: each channel knows the absolute edge of its next tick instead of a counter.
  int m_act[N_CH];
  int m_shd[N_CH];
  int m_nxt[N_CH];
  bit m_pend[N_CH];
  bit m_clk[N_CH];
  bit m_tick[N_CH];
  bit m_run[N_CH];

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at edge %0d: got=%0h expected=%0h", tag, t, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N_CH; i++) begin
      m_act[i] = DEF; m_shd[i] = DEF; m_nxt[i] = 0;
      m_pend[i] = 0; m_clk[i] = 0; m_tick[i] = 0; m_run[i] = 0;
    end
  endfunction

  function automatic void model_edge();
    for (int i = 0; i < N_CH; i++) begin
      bit hit;
      int wd;
      hit = wr_if.wr_en && (int'(wr_if.wr_ch) == i);
      wd  = int'(wr_if.wr_data);
      if (!en[i]) begin
        m_clk[i] = 0; m_tick[i] = 0; m_pend[i] = 0; m_run[i] = 0;
        m_act[i] = hit ? wd : m_shd[i];
        m_shd[i] = m_act[i];
      end else begin
        if (!m_run[i]) begin
          m_nxt[i] = t + m_act[i];
          m_run[i] = 1;
        end
        if (sync) begin
          m_clk[i] = 0; m_tick[i] = 0;
          m_nxt[i] = t + 1 + m_act[i];
          if (hit) begin m_shd[i] = wd; m_pend[i] = 1; end
        end else if (t == m_nxt[i]) begin
          m_tick[i] = 1;
          m_clk[i]  = ~m_clk[i];
          if (hit) begin m_act[i] = wd; m_shd[i] = wd; end
          else if (m_pend[i]) m_act[i] = m_shd[i];
          m_pend[i] = 0;
          m_nxt[i] = t + 1 + m_act[i];
        end else begin
          m_tick[i] = 0;
          if (hit) begin m_shd[i] = wd; m_pend[i] = 1; end
        end
      end
    end
  endfunction

  task automatic cycle();
    int et, ec, ep;
    @(posedge clk);
    t++;
    if (!rst_n) model_reset();
    else model_edge();
    @(negedge clk);
    et = 0; ec = 0; ep = 0;
    for (int i = 0; i < N_CH; i++) begin
      et |= int'(m_tick[i]) << i;
      ec |= int'(m_clk[i]) << i;
      ep |= int'(m_pend[i]) << i;
    end
    check("tick", int'(tick), et);
    check("clk_out", int'(clk_out), ec);
    check("pend", int'(wr_if.pend), ep);
  endtask

  task automatic step(input logic [N_CH-1:0] e, input logic s, input logic we, input int ch, input int d);
    en = e;
    sync = s;
    wr_if.wr_en = we;
    wr_if.wr_ch = 3'(ch);
    wr_if.wr_data = 8'(d);
    cycle();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(en, 1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    bit found;
    wr_if.wr_en = 1'b0;
    wr_if.wr_ch = '0;
    wr_if.wr_data = '0;
    en = '1;
    model_reset();

    // held in reset with enables high
    for (int k = 0; k < 3; k++) cycle();
    rst_n = 1'b1;
    idle(22);

    // asynchronous reset mid-period
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_tick", int'(tick), 0);
    check("rst_async_clk", int'(clk_out), 0);
    check("rst_async_pend", int'(wr_if.pend), 0);
    model_reset();
    cycle();
    cycle();
    rst_n = 1'b1;
    idle(10);

    // shrink ch1 mid-period
    step(4'hF, 1'b0, 1'b1, 1, 1);
    idle(12);

    // write ch2 exactly on its terminal count
    found = 0;
    for (int k = 0; k < 300 && !found; k++) begin
      if (m_run[2] && m_nxt[2] == t + 1) found = 1;
      else idle(1);
    end
    check("tc_wait", int'(found), 1);
    step(4'hF, 1'b0, 1'b1, 2, 5);
    idle(14);

    // disable with a pending divisor, then re-enable
    step(4'hF, 1'b0, 1'b1, 0, 2);
    idle(1);
    step(4'hE, 1'b0, 1'b0, 0, 0);
    idle(3);
    step(4'hF, 1'b0, 1'b0, 0, 0);
    idle(10);

    // staggered channels aligned by sync
    step(4'h0, 1'b0, 1'b1, 0, 3);
    step(4'h0, 1'b0, 1'b1, 1, 3);
    step(4'h0, 1'b0, 1'b1, 2, 7);
    step(4'h0, 1'b0, 1'b1, 3, 0);
    step(4'h1, 1'b0, 1'b0, 0, 0);
    step(4'h3, 1'b0, 1'b0, 0, 0);
    idle(2);
    step(4'h7, 1'b0, 1'b0, 0, 0);
    step(4'hF, 1'b0, 1'b0, 0, 0);
    idle(3);
    step(4'hF, 1'b1, 1'b0, 0, 0);
    idle(24);

    // widest divisor
    step(4'hF, 1'b0, 1'b1, 1, 255);
    idle(600);

    // out-of-range channel index
    step(4'hF, 1'b0, 1'b1, 4, 0);
    idle(20);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      logic [N_CH-1:0] e;
      logic s, we;
      int ch, d;
      e = en;
      if ($urandom_range(0, 39) == 0) e[$urandom_range(0, N_CH-1)] ^= 1'b1;
      s  = ($urandom_range(0, 59) == 0);
      we = ($urandom_range(0, 14) == 0);
      ch = $urandom_range(0, 4);
      d  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 9);
      step(e, s, we, ch, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/clk_divider_multi.md
# clk_divider_multi

Multi-channel, runtime-programmable clock/tick divider for the 12 MHz board clock. Each channel produces a registered divided square wave and a one-cycle enable tick. Divisors are reprogrammed through a single write port and applied glitch-free at the channel's next period boundary. Display multiplexing, blink timers and debounce samplers use it in place of fixed single-rate dividers.

## Interface
- N_CH, 4, number of independent channels (1..16)
- WIDTH, 24, divisor/counter width in bits
- DEFAULT_DIV, 5999999, reset divisor for all channels; 12 MHz clock gives 1 Hz clk_out
- clk  in  1  system clock (12 MHz on board)
- rst_n  in  1  asynchronous, active-low reset
- en  in  N_CH  per-channel run enable
- sync  in  1  one-cycle pulse; restarts every channel's period in phase
- wr_en  in  1  divisor write strobe
- wr_ch  in  max(1,clog2(N_CH))  channel index for the write
- wr_data  in  WIDTH  new divisor value D
- clk_out  out  N_CH  divided square wave, period 2*(D+1) cycles, 50% duty
- tick  out  N_CH  one-cycle pulse every D+1 cycles
- pend  out  N_CH  high while a written divisor is waiting to be applied

## Operation
- Per channel: active divisor `act`, shadow `shd`, counter `cnt` (all WIDTH bits), `pend` flag, `clk_out` register.
- Terminal count (TC): en[i]=1 and cnt==act.
- Enabled, not TC: cnt <= cnt+1. On TC: cnt <= 0, tick[i] <= 1, clk_out[i] toggles, and if pend: act <= shd, pend <= 0.
- Disabled (en[i]=0): cnt <= 0, clk_out[i] <= 0, tick[i] <= 0. Any pending divisor is applied immediately: act <= shd, pend <= 0.
- Write: wr_en=1 with wr_ch<N_CH sets shd[wr_ch] <= wr_data and pend <= 1. Writes with wr_ch>=N_CH are ignored with no state change.
- Write in the same cycle as that channel's TC: wr_data goes straight into act and pend stays 0. The new period starts immediately.
- Back-to-back writes before TC: the last one wins. pend stays 1.
- sync=1: every enabled channel gets cnt <= 0 and clk_out <= 0, with no tick. act/shd/pend are unchanged. A pending divisor then applies at the next TC. sync has priority over TC in the same cycle.
- D=0: tick is high every enabled cycle and clk_out toggles every cycle.
- The counter never exceeds act. A shrinking divisor is only loaded when cnt=0, so there is no wrap-around overrun.

## Timing
- Reset (async assert, sync release): cnt=0, act=shd=DEFAULT_DIV, pend=0, clk_out=0, tick=0.
- All outputs are registered. No combinational path from inputs to outputs.
- Enable rising at edge k (en sampled 1): the first tick and first clk_out rise are registered at the edge k+D, i.e. visible D+1 cycles after enable is first sampled.
- tick[i] is high exactly one cycle. It coincides with the clk_out[i] edge update.
- pend rises the cycle after the write edge. It falls the cycle after the applying TC or disable cycle.
- Channels are fully independent. Simultaneous writes to different channels cannot occur (single port); simultaneous TCs on all channels are legal.

## Test plan
- Reset defaults: N_CH=4, WIDTH=8, DEFAULT_DIV=3, en=4'hF after release -> tick every 4 cycles on all channels; clk_out period 8 with 4 high/4 low; all outputs 0 during reset, including reset asserted mid-period.
- Write mid-period: ch1 running D=3, write D=1 at cnt=1 -> pend[1]=1; the current period completes at 4 cycles; subsequent ticks every 2 cycles; pend[1] falls after that TC.
- Write coinciding with TC: write D=5 to ch2 exactly on its TC cycle -> pend[2] never asserts; the next tick arrives 6 cycles later.
- Disable/enable: drop en[0] mid-period -> clk_out[0]=0 and tick[0]=0 next cycle; a pending D=2 applies at once; re-enable -> first tick after 3 cycles.
- sync alignment: channels at D=3,3,7,0 with staggered enables, pulse sync -> all clk_out low next cycle; ch0 and ch1 ticks coincide thereafter; ch2 ticks every 8 cycles aligned to the sync cycle.
- Edge values: D=0 -> tick stuck high and clk_out toggles every cycle; D=255 (WIDTH=8) -> 256-cycle tick period with no overflow; write with wr_ch=4 (out of range) -> no channel changes.
